// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM states, data-bit
// encodings, per-character flag positions and data-width helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_e;

  localparam logic [1:0] BITS_5 = 2'b00;
  localparam logic [1:0] BITS_6 = 2'b01;
  localparam logic [1:0] BITS_7 = 2'b10;
  localparam logic [1:0] BITS_8 = 2'b11;

  localparam int DATA_W  = 8;
  localparam int FLAGS_W = 3;

  localparam int FLAG_PARITY = 0;
  localparam int FLAG_FRAME  = 1;
  localparam int FLAG_BREAK  = 2;

  // Index of the last data bit of a character (N-1).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] bits);
    case (bits)
      BITS_5: return 3'd4;
      BITS_6: return 3'd5;
      BITS_7: return 3'd6;
      BITS_8: return 3'd7;
    endcase
  endfunction

  // Bits are shifted in from the MSB end, so short characters sit high.
  function automatic logic [DATA_W-1:0] right_justify(input logic [DATA_W-1:0] sh,
                                                      input logic [1:0] bits);
    case (bits)
      BITS_5: return sh >> 3;
      BITS_6: return sh >> 2;
      BITS_7: return sh >> 1;
      BITS_8: return sh;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_buf_if.sv
// Receive-FIFO drain handshake between the receiver (master) and the
// register block (slave).
interface uart_rx_buf_if;
  logic [7:0] rx_data_o;
  logic [2:0] rx_flags_o;
  logic       rx_valid_o;
  logic       rx_ready_i;

  modport master (output rx_data_o, output rx_flags_o, output rx_valid_o, input rx_ready_i);
  modport slave  (input rx_data_o, input rx_flags_o, input rx_valid_o, output rx_ready_i);
endinterface

// File: rtl/uart_sync_fifo.sv
// First-word fall-through synchronous FIFO with wrap-bit pointers; the head
// reads as zero whenever the FIFO is empty.
module uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clr_i,
  input  logic [WIDTH-1:0]         push_data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A pop frees the slot the same edge, so a full FIFO can still accept.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_buf.sv
// Configurable UART receiver (5-8 data bits, parity, 1/2 stop bits, break
// detection) feeding a receive FIFO with per-character flags and sticky status.
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        rx_i,
  input  logic                        cfg_en_i,
  input  logic [DIV_W-1:0]            cfg_div_i,
  input  logic [1:0]                  cfg_bits_i,
  input  logic                        cfg_parity_en_i,
  input  logic                        cfg_parity_odd_i,
  input  logic                        cfg_stop2_i,
  input  logic                        fifo_clr_i,
  input  logic                        err_clr_i,
  uart_rx_buf_if.master               rx_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        busy_o,
  output logic                        err_parity_o,
  output logic                        err_frame_o,
  output logic                        err_overrun_o,
  output logic                        break_o
);

  rx_state_e          state_q;
  logic               busy_q;
  logic [DIV_W-1:0]   cnt_q;
  logic [2:0]         bit_idx_q;
  logic [DATA_W-1:0]  shreg_q;
  logic               par_acc_q, par_err_q, ones_q, frame_q, brk_q;
  logic               sync1_q, sync2_q, hist_q;
  logic               line, fall, tick;
  logic               push_req, push_ok, pop, overrun_set, fifo_full, fifo_empty;
  logic [FLAGS_W-1:0] push_flags;
  logic [DATA_W-1:0]  push_data;
  logic [DATA_W+FLAGS_W-1:0] head;
  logic err_parity_q, err_frame_q, err_overrun_q, break_q;
  logic err_parity_d, err_frame_d, err_overrun_d, break_d;

  // Held at idle-high while disabled so re-enabling never fakes a start edge.
  always_ff @(posedge clk_i) begin
    if (rst_i || !cfg_en_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign line = sync2_q;
  assign fall = hist_q & ~sync2_q;
  assign tick = (state_q == ST_START) ? (cnt_q == (cfg_div_i >> 1)) : (cnt_q == cfg_div_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || !cfg_en_i) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_acc_q <= 1'b0;
      par_err_q <= 1'b0;
      ones_q    <= 1'b0;
      frame_q   <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      cnt_q <= (state_q == ST_IDLE || tick) ? '0 : cnt_q + DIV_W'(1);
      case (state_q)
        ST_IDLE: if (fall) begin
          state_q   <= ST_START;
          busy_q    <= 1'b1;
          bit_idx_q <= '0;
          par_acc_q <= 1'b0;
          par_err_q <= 1'b0;
          ones_q    <= 1'b0;
        end
        ST_START: if (tick) begin
          state_q <= line ? ST_IDLE : ST_DATA;
          busy_q  <= ~line;
        end
        ST_DATA: if (tick) begin
          shreg_q   <= {line, shreg_q[DATA_W-1:1]};
          par_acc_q <= par_acc_q ^ line;
          ones_q    <= ones_q | line;
          bit_idx_q <= bit_idx_q + 3'd1;
          if (bit_idx_q == last_bit_idx(cfg_bits_i))
            state_q <= cfg_parity_en_i ? ST_PARITY : ST_STOP1;
        end
        ST_PARITY: if (tick) begin
          par_err_q <= par_acc_q ^ line ^ cfg_parity_odd_i;
          ones_q    <= ones_q | line;
          state_q   <= ST_STOP1;
        end
        ST_STOP1: if (tick) begin
          frame_q <= ~line;
          brk_q   <= ~ones_q & ~line;
          state_q <= cfg_stop2_i ? ST_STOP2 : ST_IDLE;
          busy_q  <= cfg_stop2_i;
        end
        ST_STOP2: if (tick) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push_req                = 1'b0;
    push_flags              = '0;
    push_flags[FLAG_PARITY] = par_err_q;
    if (state_q == ST_STOP1) begin
      push_flags[FLAG_FRAME] = ~line;
      push_flags[FLAG_BREAK] = ~ones_q & ~line;
      push_req               = tick & ~cfg_stop2_i;
    end else if (state_q == ST_STOP2) begin
      push_flags[FLAG_FRAME] = frame_q | ~line;
      push_flags[FLAG_BREAK] = brk_q;
      push_req               = tick;
    end
    push_req = push_req & cfg_en_i;
  end

  assign push_data   = right_justify(shreg_q, cfg_bits_i);
  assign push_ok     = push_req & ~fifo_clr_i;
  assign pop         = rx_if.rx_ready_i & ~fifo_empty;
  assign overrun_set = push_ok & fifo_full & ~pop;

  uart_sync_fifo #(.WIDTH(DATA_W + FLAGS_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_ok),
    .pop_i       (rx_if.rx_ready_i),
    .clr_i       (fifo_clr_i),
    .push_data_i ({push_flags, push_data}),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count_o),
    .head_o      (head)
  );

  // A set in the same cycle as the clear wins.
  always_comb begin
    err_parity_d  = (err_parity_q  & ~err_clr_i) | (push_ok & push_flags[FLAG_PARITY]);
    err_frame_d   = (err_frame_q   & ~err_clr_i) | (push_ok & push_flags[FLAG_FRAME]);
    break_d       = (break_q       & ~err_clr_i) | (push_ok & push_flags[FLAG_BREAK]);
    err_overrun_d = (err_overrun_q & ~err_clr_i) | overrun_set;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_parity_q  <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      break_q       <= 1'b0;
    end else begin
      err_parity_q  <= err_parity_d;
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
      break_q       <= break_d;
    end
  end

  assign rx_if.rx_data_o  = head[DATA_W-1:0];
  assign rx_if.rx_flags_o = head[DATA_W+FLAGS_W-1:DATA_W];
  assign rx_if.rx_valid_o = ~fifo_empty;
  assign busy_o           = busy_q;
  assign err_parity_o     = err_parity_q;
  assign err_frame_o      = err_frame_q;
  assign err_overrun_o    = err_overrun_q;
  assign break_o          = break_q;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Self-checking bench for uart_rx_buf: serial frames are built from the
// character rules and compared against a queue model of the receive FIFO.
module tb_uart_rx_buf;
  import uart_pkg::*;

  localparam int DEPTH = 4;
  localparam int DIV_W = 16;

  logic              clk_i = 1'b0;
  logic              rst_i, rx_i, cfg_en_i;
  logic [DIV_W-1:0]  cfg_div_i;
  logic [1:0]        cfg_bits_i;
  logic              cfg_parity_en_i, cfg_parity_odd_i, cfg_stop2_i;
  logic              fifo_clr_i, err_clr_i;
  logic [$clog2(DEPTH):0] fifo_count_o;
  logic              busy_o, err_parity_o, err_frame_o, err_overrun_o, break_o;

  uart_rx_buf_if rx_if ();

  uart_rx_buf #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .rx_i             (rx_i),
    .cfg_en_i         (cfg_en_i),
    .cfg_div_i        (cfg_div_i),
    .cfg_bits_i       (cfg_bits_i),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_odd_i (cfg_parity_odd_i),
    .cfg_stop2_i      (cfg_stop2_i),
    .fifo_clr_i       (fifo_clr_i),
    .err_clr_i        (err_clr_i),
    .rx_if            (rx_if),
    .fifo_count_o     (fifo_count_o),
    .busy_o           (busy_o),
    .err_parity_o     (err_parity_o),
    .err_frame_o      (err_frame_o),
    .err_overrun_o    (err_overrun_o),
    .break_o          (break_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {flags, data} plus the four sticky bits.
  logic [10:0] exp_q[$];
  logic m_par = 1'b0, m_frm = 1'b0, m_ovr = 1'b0, m_brk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Every pop seen by the DUT must present the oldest expected character.
  always @(negedge clk_i) begin
    if (!rst_i && rx_if.rx_valid_o && rx_if.rx_ready_i) begin
      if (exp_q.size() == 0) begin
        check("pop_on_empty_model", 32'(rx_if.rx_valid_o), 32'd0);
      end else begin
        check("head_data", 32'(rx_if.rx_data_o), 32'(exp_q[0][7:0]));
        check("head_flags", 32'(rx_if.rx_flags_o), 32'(exp_q[0][10:8]));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic model_push(input logic [10:0] e);
    if (!cfg_en_i) return;
    m_par |= e[8 + FLAG_PARITY];
    m_frm |= e[8 + FLAG_FRAME];
    m_brk |= e[8 + FLAG_BREAK];
    if (exp_q.size() == DEPTH) m_ovr = 1'b1;
    else exp_q.push_back(e);
  endtask

  function automatic int frame_bits();
    return 5 + int'(cfg_bits_i) + int'(cfg_parity_en_i) + 1 + int'(cfg_stop2_i);
  endfunction

  // Clock edges from the start of the start bit to the edge that stores the character.
  function automatic int push_offset();
    return 4 + int'(cfg_div_i >> 1) + (int'(cfg_div_i) + 1) * frame_bits();
  endfunction

  task automatic send(input logic [7:0] d, input logic par_flip, input logic s1, input logic s2);
    int          n, per;
    logic [7:0]  dm;
    logic        pbit;
    logic [2:0]  fl;
    logic        seq[$];
    n    = 5 + int'(cfg_bits_i);
    dm   = d & 8'((1 << n) - 1);
    pbit = (^dm) ^ cfg_parity_odd_i ^ par_flip;
    seq.push_back(1'b0);
    for (int i = 0; i < n; i++) seq.push_back(dm[i]);
    if (cfg_parity_en_i) seq.push_back(pbit);
    seq.push_back(s1);
    if (cfg_stop2_i) seq.push_back(s2);
    per = int'(cfg_div_i) + 1;
    foreach (seq[i]) begin
      rx_i = seq[i];
      tick(per);
    end
    rx_i = 1'b1;
    fl[FLAG_PARITY] = cfg_parity_en_i & ((^dm) ^ pbit ^ cfg_parity_odd_i);
    fl[FLAG_FRAME]  = ~s1 | (cfg_stop2_i & ~s2);
    fl[FLAG_BREAK]  = (dm == 8'd0) && (!cfg_parity_en_i || !pbit) && !s1;
    model_push({fl, dm});
  endtask

  task automatic quiesce(input string tag);
    int n = 0;
    while (busy_o && n < 2000) begin
      tick(1);
      n++;
    end
    check({tag, "_idle"}, 32'(busy_o), 32'd0);
    tick(4);
    check({tag, "_count"}, 32'(fifo_count_o), 32'(exp_q.size()));
    check({tag, "_valid"}, 32'(rx_if.rx_valid_o), 32'(exp_q.size() != 0));
    check({tag, "_sticky"}, {28'd0, break_o, err_overrun_o, err_frame_o, err_parity_o},
          {28'd0, m_brk, m_ovr, m_frm, m_par});
  endtask

  task automatic drain();
    int n = 0;
    rx_if.rx_ready_i = 1'b1;
    while (rx_if.rx_valid_o && n < 4 * DEPTH) begin
      tick(1);
      n++;
    end
    rx_if.rx_ready_i = 1'b0;
    check("drain_empty", 32'(rx_if.rx_valid_o), 32'd0);
  endtask

  task automatic clear_errors();
    err_clr_i = 1'b1;
    tick(1);
    err_clr_i = 1'b0;
    {m_par, m_frm, m_ovr, m_brk} = 4'b0;
  endtask

  task automatic set_cfg(input int div, input logic [1:0] bits, input logic pen,
                         input logic podd, input logic st2);
    cfg_div_i = DIV_W'(div);
    cfg_bits_i = bits;
    cfg_parity_en_i = pen;
    cfg_parity_odd_i = podd;
    cfg_stop2_i = st2;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, off;
    rst_i = 1'b1; rx_i = 1'b1; cfg_en_i = 1'b1;
    fifo_clr_i = 1'b0; err_clr_i = 1'b0; rx_if.rx_ready_i = 1'b0;
    set_cfg(15, BITS_8, 1'b0, 1'b0, 1'b0);
    tick(3);
    rst_i = 1'b0;
    tick(1);
    check("rst_valid", 32'(rx_if.rx_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_count", 32'(fifo_count_o), 32'd0);
    check("rst_head", {21'd0, rx_if.rx_flags_o, rx_if.rx_data_o}, 32'd0);
    check("rst_sticky", {28'd0, break_o, err_overrun_o, err_frame_o, err_parity_o}, 32'd0);

    // 8N1 0xA5: valid rises 1+8+16*9 cycles after the fall is detected (2 edges in).
    lat = 0;
    fork
      send(8'hA5, 1'b0, 1'b1, 1'b1);
      begin
        while (!rx_if.rx_valid_o && lat < 400) begin
          @(negedge clk_i);
          lat++;
        end
      end
    join
    check("a5_latency_in_window", 32'((lat - 1 - 2 >= 151) && (lat - 1 - 2 <= 155)), 32'd1);
    quiesce("a5");
    check("a5_data", 32'(rx_if.rx_data_o), 32'hA5);
    check("a5_flags", 32'(rx_if.rx_flags_o), 32'd0);
    drain();

    // 7E2 with a corrupted parity bit.
    set_cfg(15, BITS_7, 1'b1, 1'b0, 1'b1);
    send(8'h3C, 1'b1, 1'b1, 1'b1);
    quiesce("par");
    check("par_data", 32'(rx_if.rx_data_o), 32'h3C);
    check("par_flags", 32'(rx_if.rx_flags_o), 32'b001);
    check("par_sticky", 32'(err_parity_o), 32'd1);
    clear_errors();
    tick(1);
    check("par_cleared", 32'(err_parity_o), 32'd0);
    drain();

    // Break: 0x00 with stop bit held low.
    set_cfg(15, BITS_8, 1'b0, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0, 1'b1);
    quiesce("brk");
    check("brk_flags", 32'(rx_if.rx_flags_o), 32'b110);
    check("brk_status", {30'd0, break_o, err_frame_o}, 32'b11);
    drain();
    clear_errors();

    // 6-cycle glitch is rejected at the half-bit sample.
    set_cfg(31, BITS_8, 1'b0, 1'b0, 1'b0);
    rx_i = 1'b0;
    tick(6);
    rx_i = 1'b1;
    check("glitch_busy_seen", 32'(busy_o), 32'd1);
    tick(40);
    quiesce("glitch");

    // Five characters into a depth-4 FIFO without popping.
    set_cfg(7, BITS_8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b0, 1'b1, 1'b1);
    quiesce("ovr");
    check("ovr_count", 32'(fifo_count_o), 32'd4);
    check("ovr_flag", 32'(err_overrun_o), 32'd1);
    drain();
    clear_errors();

    // Same again, but a pop lands on the edge that stores the fifth character.
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 1'b0, 1'b1, 1'b1);
    off = push_offset();
    fork
      send(8'h24, 1'b0, 1'b1, 1'b1);
      begin
        tick(off - 1);
        rx_if.rx_ready_i = 1'b1;
        tick(1);
        rx_if.rx_ready_i = 1'b0;
      end
    join
    quiesce("coinc");
    check("coinc_count", 32'(fifo_count_o), 32'd4);
    check("coinc_no_ovr", 32'(err_overrun_o), 32'd0);
    drain();

    // Receiver disabled mid-DATA, then re-enabled.
    set_cfg(15, BITS_8, 1'b0, 1'b0, 1'b0);
    fork
      send(8'h77, 1'b0, 1'b1, 1'b1);
      begin
        tick(40);
        check("en_busy_before", 32'(busy_o), 32'd1);
        cfg_en_i = 1'b0;
        tick(1);
        check("en_busy_after", 32'(busy_o), 32'd0);
      end
    join
    cfg_en_i = 1'b1;
    tick(3);
    quiesce("en_off");
    send(8'h5A, 1'b0, 1'b1, 1'b1);
    quiesce("en_on");
    check("en_data", 32'(rx_if.rx_data_o), 32'h5A);

    // Flush discards buffered characters.
    send(8'h66, 1'b0, 1'b1, 1'b1);
    quiesce("clr_pre");
    fifo_clr_i = 1'b1;
    tick(1);
    fifo_clr_i = 1'b0;
    exp_q.delete();
    check("clr_count", 32'(fifo_count_o), 32'd0);
    check("clr_head", {21'd0, rx_if.rx_flags_o, rx_if.rx_data_o}, 32'd0);

    // Randomised frames across formats, dividers, errors and breaks.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] d;
      set_cfg(3 + $urandom_range(0, 17), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      d = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
      send(d, ($urandom % 4) == 0, ($urandom % 5) != 0, ($urandom % 5) != 0);
      quiesce("rnd");
      if ($urandom % 3 == 0) drain();
      if ($urandom % 5 == 0) clear_errors();
    end
    drain();
    quiesce("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_buf.md
# uart_rx_buf

Parametrised next-generation UART receiver for the APB UART peripheral: supports 5–8 data bits, even/odd/no parity, and 1 or 2 stop bits, with false-start rejection and break detection. Each received character is written, with per-character error flags, into an internal receive FIFO. The register block drains the FIFO through a valid/ready interface and reads sticky error status.

## Interface
- FIFO_DEPTH, 8, receive FIFO entries; power of two, ≥2
- DIV_W, 16, width of the baud divider
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous and active-high
- rx_i  in  1  serial line, asynchronous, idle high
- cfg_en_i  in  1  receiver enable
- cfg_div_i  in  DIV_W  bit period minus one, in clk_i cycles; valid range ≥3
- cfg_bits_i  in  2  data bits: 00→5, 01→6, 10→7, 11→8
- cfg_parity_en_i  in  1  parity bit present
- cfg_parity_odd_i  in  1  1 = odd parity, 0 = even parity
- cfg_stop2_i  in  1  two stop bits
- fifo_clr_i  in  1  flush the FIFO
- err_clr_i  in  1  clear all sticky errors
- rx_data_o  out  8  FIFO head data, right-justified, unused upper bits 0
- rx_flags_o  out  3  head flags {break, frame, parity}
- rx_valid_o  out  1  FIFO not empty
- rx_ready_i  in  1  pop the head when rx_valid_o=1
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current fill level
- busy_o  out  1  FSM is not in IDLE
- err_parity_o, err_frame_o, err_overrun_o, break_o  out  1 each  sticky status

## Operation
- Input synchronisation: 2-flop synchroniser plus one history flop. A fall is detected when the history flop is 1 and the synchronised value is 0. While cfg_en_i=0, all three flops are forced to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: on a detected fall → START. Baud counter cleared.
  - START: at the half-bit tick, if the line is 1 → IDLE (false start, nothing pushed). Otherwise → DATA.
  - DATA: at each full-bit tick, shift the sample in LSB-first and XOR it into the parity accumulator. After N bits, → PARITY if cfg_parity_en_i=1, else → STOP1.
  - PARITY: at the tick, parity_err = accumulator ^ sample ^ cfg_parity_odd_i. Then → STOP1.
  - STOP1: at the tick, frame_err = ~sample. Then → STOP2 if cfg_stop2_i=1, else push and → IDLE.
  - STOP2: at the tick, frame_err |= ~sample. Then push and → IDLE.
- Break: data all zero, parity sample 0 if parity is enabled, and STOP1 sample 0. Break is flagged in addition to frame.
- Push: writes {flags, data} into the FIFO and ORs the flags into the sticky bits.
- Overrun: if the FIFO is full and not popped in the same cycle, the push is dropped and err_overrun_o is set.
- Push and pop in the same cycle when full: both happen, count is unchanged, no overrun.
- Sticky bits: err_clr_i clears them. A set in the same cycle as err_clr_i wins.
- cfg_en_i=0: FSM → IDLE next cycle and any partial character is discarded. FIFO contents and sticky bits are retained.
- fifo_clr_i: count → 0 next cycle. A push in the same cycle is discarded.
- cfg_* inputs must stay stable while busy_o=1; otherwise behaviour is undefined but the FSM must not lock up.

## Timing
- Reset (rst_i=1 at a clk_i edge): FSM=IDLE, FIFO empty; rx_valid_o, busy_o, fifo_count_o and all sticky bits = 0; rx_data_o=0 and rx_flags_o=0, because the head is gated to 0 when empty. Reset mid-character discards it.
- Baud counter: cleared on entering START. Half tick when count == cfg_div_i>>1; each later tick when count == cfg_div_i. The counter restarts at 0 on each tick, so ticks are cfg_div_i+1 cycles apart.
- FIFO is first-word fall-through: a push at edge t gives rx_valid_o=1 after edge t. A pop at edge t updates the head after edge t.
- busy_o falls in the cycle after the push.
- Line-to-first-fall-detect latency: 3 cycles.

## Structure
- uart_pkg holds:
  - rx_state_e enum
  - bits encoding constants
  - flag bit indices FLAG_PARITY=0, FLAG_FRAME=1, FLAG_BREAK=2
- Sub-module uart_sync_fifo #(WIDTH, DEPTH):
  - ports: push, pop, clr, full, empty, count, head
  - pointers of width $clog2(DEPTH)+1 with wrap bit

## Test plan
- cfg_div_i=15, 8N1, send 0xA5 → 0xA5 with flags 000. rx_valid_o rises (after the fall is detected) at 1 + 8 + 16×9 cycles ±2.
- 7E2, send 0x3C with a wrong parity bit → rx_data_o=0x3C, flags=001, err_parity_o=1. err_clr_i then clears it.
- 8N1, stop bit held 0 on 0x00 → flags=110; break_o=1 and err_frame_o=1.
- 6-cycle low glitch with cfg_div_i=31 → no push, busy_o returns to 0, FIFO count stays 0.
- FIFO_DEPTH=4, send 5 characters with no pop → count=4, first 4 characters intact, err_overrun_o=1. Repeat with a pop coinciding with the 5th push → count=4, no overrun.
- Drop cfg_en_i mid-DATA → busy_o=0 after 1 cycle, no push. Reassert cfg_en_i and send 0x5A → received correctly.
